sram_2p: RTL and testbench

- Parametrised simple-dual-port register-array SRAM: one write port and one independent read port.
- Successor to the team's 32x8 single-port SRAM. Adds:
  - configurable width and depth;
  - concurrent read and write in the same cycle;
  - a selectable read-during-write policy;
  - a registered read with a valid strobe;
  - a sequenced whole-array clear command with a busy flag.
- Sits between datapath producers and consumers as a small scratch/buffer memory.

---
 rtl/sram_2p.sv | 113 +++++++++++
 tb/tb_sram_2p.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_2p.sv
// Simple-dual-port register-array SRAM: one write port, one registered read port,
// selectable read-during-write policy and a sequenced whole-array clear.
module sram_2p #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int RDW_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clr,
    output logic              busy
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic              wr_ok;
    logic              rd_ok;

    assign busy  = (state == CLEAR);
    // A clr request in the same cycle drops any write or read.
    assign wr_ok = !busy && !clr && wr_en && ({1'b0, wr_addr} < DEPTH_L);
    assign rd_ok = !busy && !clr && rd_en;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    // NOTE: every always_comb output gets a default first; a missed branch
    // would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nx = CLEAR;
                    ptr_nx   = '0;
                end
            end
            CLEAR: begin
                if (ptr == LAST) begin
                    state_nx = IDLE;
                    ptr_nx   = '0;
                end else begin
                    ptr_nx = ptr + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                ptr_nx   = '0;
            end
        endcase
    end

    // NOTE: the array is a register file, so it is reset like any other
    // flop; a macro SRAM could not be, and would rely on the clear sequence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy && ptr == ADDR_W'(i)) mem[i] <= '0;
                else if (wr_ok && wr_addr == ADDR_W'(i)) mem[i] <= wr_data;
            end
        end
    end

    // Out-of-range read addresses fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_word = mem[i];
        end
        if (RDW_MODE == 1 && wr_ok && wr_addr == rd_addr) rd_word = wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) rd_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_sram_2p.sv
// Self-checking bench for sram_2p: three instances (old-data, write-through,
// DEPTH=20) share one stimulus stream and are compared against a word-level model.
module tb_sram_2p;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, rd_en, clr;
    logic [4:0] wr_addr, rd_addr;
    logic [7:0] wr_data;

    logic [7:0] d0, d1, d2;
    logic       v0, v1, v2;
    logic       b0, b1, b2;

    int n_err    = 0;
    int n_checks = 0;

    int         dp [3] = '{32, 32, 20};
    int         md [3] = '{0, 1, 0};
    logic [7:0] m_mem  [3][32];
    logic [7:0] m_rd   [3];
    logic       m_v    [3];
    int         m_busy [3];

    always #5 clk = ~clk;

    sram_2p #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RDW_MODE(0)) u_old (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0), .clr(clr), .busy(b0));

    sram_2p #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RDW_MODE(1)) u_wt (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1), .clr(clr), .busy(b1));

    sram_2p #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .RDW_MODE(0)) u_d20 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d2), .rd_valid(v2), .clr(clr), .busy(b2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/old.rd_data"}, d0, m_rd[0]);
        check({tag, "/old.rd_valid"}, v0, m_v[0]);
        check({tag, "/old.busy"}, b0, m_busy[0] > 0);
        check({tag, "/wt.rd_data"}, d1, m_rd[1]);
        check({tag, "/wt.rd_valid"}, v1, m_v[1]);
        check({tag, "/wt.busy"}, b1, m_busy[1] > 0);
        check({tag, "/d20.rd_data"}, d2, m_rd[2]);
        check({tag, "/d20.rd_valid"}, v2, m_v[2]);
        check({tag, "/d20.busy"}, b2, m_busy[2] > 0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 32; a++) m_mem[k][a] = 8'h00;
            m_rd[k]   = 8'h00;
            m_v[k]    = 1'b0;
            m_busy[k] = 0;
        end
    endtask

    // A clear is modelled as zeroing the array at once and then counting
    // down DEPTH cycles during which nothing is accepted.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (m_busy[k] > 0) begin
                m_busy[k]--;
                m_v[k] = 1'b0;
            end else if (clr) begin
                for (int a = 0; a < 32; a++) m_mem[k][a] = 8'h00;
                m_busy[k] = dp[k];
                m_v[k]    = 1'b0;
            end else begin
                m_v[k] = rd_en;
                if (rd_en) begin
                    if (int'(rd_addr) >= dp[k]) m_rd[k] = 8'h00;
                    else if (md[k] == 1 && wr_en && wr_addr == rd_addr) m_rd[k] = wr_data;
                    else m_rd[k] = m_mem[k][rd_addr];
                end
                if (wr_en && int'(wr_addr) < dp[k]) m_mem[k][wr_addr] = wr_data;
            end
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [7:0] wd,
                         input logic re, input logic [4:0] ra, input logic c);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; clr = c;
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    // Reset is asserted mid-cycle and checked before any clock edge.
    task automatic apply_reset(input string tag);
        #2;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0, cnt2;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // Test 1: back-to-back reads after reset, reset asserted mid-stream.
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 1, 5'(i), 0);
            tick($sformatf("t1_rd%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 1, 5'(i), 0);
            tick($sformatf("t1_rd2_%0d", i));
        end
        apply_reset("t1_midreset");
        check("t1_midreset_valid", v0, 1'b0);

        // Test 2: fill with A0+i, read back descending, then hold.
        for (int i = 0; i < 32; i++) begin
            drive(1, 5'(i), 8'hA0 + 8'(i), 0, 0, 0);
            tick($sformatf("t2_wr%0d", i));
        end
        for (int i = 31; i >= 0; i--) begin
            drive(0, 0, 0, 1, 5'(i), 0);
            tick($sformatf("t2_rd%0d", i));
            check($sformatf("t2_const%0d", i), d0, 8'hA0 + 8'(i));
        end
        drive(0, 0, 0, 0, 0, 0);
        tick("t2_idle");
        check("t2_hold_data", d0, 8'hA0);
        check("t2_hold_valid", v0, 1'b0);

        // Test 3: read-during-write policy.
        drive(1, 5, 8'h11, 0, 0, 0);
        tick("t3_wr11");
        drive(1, 5, 8'h22, 1, 5, 0);
        tick("t3_rdw");
        check("t3_old_data", d0, 8'h11);
        check("t3_write_through", d1, 8'h22);
        drive(0, 0, 0, 1, 5, 0);
        tick("t3_reread");
        check("t3_reread_old", d0, 8'h22);
        drive(1, 7, 8'h99, 1, 5, 0);
        tick("t3_diff_addr");
        check("t3_diff_addr_old", d0, 8'h22);
        check("t3_diff_addr_wt", d1, 8'h22);

        // Test 4: clear with colliding requests and random traffic while busy.
        for (int i = 0; i < 32; i++) begin
            drive(1, 5'(i), 8'hFF, 0, 0, 0);
            tick($sformatf("t4_fill%0d", i));
        end
        drive(1, 3, 8'h55, 1, 3, 1);
        tick("t4_clr");
        check("t4_clr_read_dropped", v0, 1'b0);
        cnt0 = 0;
        cnt2 = 0;
        for (int c = 0; c < 40; c++) begin
            if (b0) cnt0++;
            if (b2) cnt2++;
            if (c < 28)
                drive(1'($urandom), 5'($urandom), 8'($urandom), 1'($urandom), 5'($urandom),
                      (c < 15) ? 1'($urandom) : 1'b0);
            else
                drive(0, 0, 0, 0, 0, 0);
            tick($sformatf("t4_busy%0d", c));
        end
        check("t4_busy_len32", cnt0, 32);
        check("t4_busy_len20", cnt2, 20);
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 1, 5'(i), 0);
            tick($sformatf("t4_rd%0d", i));
            check($sformatf("t4_zero%0d", i), d0, 8'h00);
        end

        // Test 5: reset in the 10th busy cycle of a clear.
        drive(0, 0, 0, 0, 0, 1);
        tick("t5_clr");
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 9; c++) tick($sformatf("t5_busy%0d", c));
        check("t5_busy_before_reset", b0, 1'b1);
        apply_reset("t5_reset");
        check("t5_busy_after_reset", b0, 1'b0);
        drive(1, 0, 8'h3C, 0, 0, 0);
        tick("t5_wr3c");
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 0, 1, 5'(i), 0);
            tick($sformatf("t5_rd%0d", i));
            check($sformatf("t5_const%0d", i), d0, (i == 0) ? 8'h3C : 8'h00);
        end

        // Test 6: out-of-range access on the DEPTH=20 instance.
        drive(1, 25, 8'h77, 0, 0, 0);
        tick("t6_wr25");
        drive(0, 0, 0, 1, 25, 0);
        tick("t6_rd25");
        check("t6_oor_data", d2, 8'h00);
        check("t6_oor_valid", v2, 1'b1);
        check("t6_inrange_data", d0, 8'h77);

        // Random traffic with occasional clears.
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom), 5'($urandom), 8'($urandom), 1'($urandom), 5'($urandom),
                  ($urandom_range(0, 39) == 0));
            tick($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
